// File: rtl/dmem_pkg.sv
// dmem_pkg: opcode constants and opcode field position shared by the data-memory stage.
package dmem_pkg;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam logic [5:0] OPC_LW  = 6'd35;
    localparam logic [5:0] OPC_SW  = 6'd43;
    localparam logic [5:0] OPC_LB  = 6'd32;
    localparam logic [5:0] OPC_LBU = 6'd36;
    localparam logic [5:0] OPC_SB  = 6'd40;
endpackage

// File: rtl/dmem_decode.sv
// dmem_decode: maps a byte address to word index, byte lane, range and word-alignment flags.
module dmem_decode
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int BASE_ADDR = 388
) (
    input  logic [DATA_W-1:0]          addr,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic [1:0]                 byte_sel,
    output logic                       in_range,
    output logic                       aligned
);
    logic [DATA_W-1:0] off;
    always_comb begin
        off      = addr - DATA_W'(BASE_ADDR);
        idx      = off[$clog2(DEPTH)+1:2];
        byte_sel = off[1:0];
        // addresses below the base are rejected explicitly so the subtraction never wraps into range
        in_range = (addr >= DATA_W'(BASE_ADDR)) && ((off >> 2) < DATA_W'(DEPTH));
        aligned  = off[1:0] == 2'b00;
    end
endmodule

// File: rtl/dmem_stage_param.sv
// dmem_stage_param: parametrised MEM stage with word/byte access, stall, error flag and debug read.
// Optional sticky error (err_sticky/err_clr) is built when DMEM_STICKY_ERR_EN is defined.
module dmem_stage_param
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int BASE_ADDR = 388,
    parameter int INIT_IDX  = 4,
    parameter int INIT_VAL  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [31:0]              Instruction_MEM,
    input  logic [DATA_W-1:0]        Alu_result,
    input  logic [DATA_W-1:0]        Write_data_mem,
    output logic [31:0]              Instruction_WB,
    output logic [DATA_W-1:0]        Read_data_mem,
    output logic                     mem_err,
    input  logic [$clog2(DEPTH)-1:0] dbg_idx,
    output logic [DATA_W-1:0]        dbg_data
`ifdef DMEM_STICKY_ERR_EN
    ,
    input  logic                     err_clr,
    output logic                     err_sticky
`endif
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [$clog2(DEPTH)-1:0] idx;
    logic [1:0] byte_sel;
    logic in_range, aligned;
    logic [5:0] opc;
    logic is_load, is_store, ok, err_next;
    logic [DATA_W-1:0] cur, wdata, ldata, rd_next;
    logic [7:0] lane;

    dmem_decode #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_decode (
        .addr(Alu_result),
        .idx(idx),
        .byte_sel(byte_sel),
        .in_range(in_range),
        .aligned(aligned)
    );

    always_comb begin
        opc      = Instruction_MEM[OPC_MSB:OPC_LSB];
        is_load  = opc == OPC_LW || opc == OPC_LB || opc == OPC_LBU;
        is_store = opc == OPC_SW || opc == OPC_SB;
        ok       = in_range && (aligned || !(opc == OPC_LW || opc == OPC_SW));
        err_next = (is_load || is_store) && !ok;
        cur      = mem[idx];
        lane     = cur[{byte_sel, 3'b000} +: 8];
        wdata    = cur;
        wdata[{byte_sel, 3'b000} +: 8] = Write_data_mem[7:0];
        wdata    = (opc == OPC_SW) ? Write_data_mem : wdata;
        ldata    = (opc == OPC_LW) ? cur :
                   (opc == OPC_LB) ? {{(DATA_W-8){lane[7]}}, lane} : {{(DATA_W-8){1'b0}}, lane};
        rd_next  = is_load ? (ok ? ldata : '0) : Alu_result;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            Instruction_WB <= '0;
            Read_data_mem  <= '0;
            mem_err        <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i == INIT_IDX) ? DATA_W'(INIT_VAL) : '0;
        end else if (!stall) begin
            Instruction_WB <= Instruction_MEM;
            Read_data_mem  <= rd_next;
            mem_err        <= err_next;
            if (is_store && ok)
                mem[idx] <= wdata;
        end
    end

`ifdef DMEM_STICKY_ERR_EN
    // set has priority over clear when both happen in the same cycle
    always_ff @(posedge clk) begin
        if (!reset)
            err_sticky <= 1'b0;
        else if (!stall && err_next)
            err_sticky <= 1'b1;
        else if (err_clr)
            err_sticky <= 1'b0;
    end
`endif

    assign dbg_data = (int'(dbg_idx) < DEPTH) ? mem[dbg_idx] : '0;
endmodule

// File: tb/tb_dmem_stage_param.sv
// tb_dmem_stage_param: scoreboard bench; the driver queues expected WB results, a monitor checks them.
module tb_dmem_stage_param;
    localparam logic [5:0] LW = 6'd35, SW = 6'd43, LB = 6'd32, LBU = 6'd36, SB = 6'd40, ADD = 6'd0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rd;
        logic        chk_rd;
        logic        err;
    } exp_t;

    logic clk = 0;
    logic reset, stall;
    logic [31:0] instr_mem, alu, wdat, instr_wb, rd_mem, dbg_data;
    logic mem_err;
    logic [2:0] dbg_idx;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;

    dmem_stage_param dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .Instruction_MEM(instr_mem),
        .Alu_result(alu),
        .Write_data_mem(wdat),
        .Instruction_WB(instr_wb),
        .Read_data_mem(rd_mem),
        .mem_err(mem_err),
        .dbg_idx(dbg_idx),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_dbg(input logic [2:0] i, input logic [31:0] exp);
        dbg_idx = i;
        #1;
        chk($sformatf("dbg_data[%0d]", i), dbg_data, exp);
    endtask

    task automatic issue(input logic [5:0] op, input int tag, input logic [31:0] a, input logic [31:0] d,
                         input logic chk_rd, input logic [31:0] rd, input logic err);
        exp_t e;
        @(negedge clk);
        instr_mem = {op, 26'(tag)};
        alu = a;
        wdat = d;
        @(posedge clk);
        e.instr = {op, 26'(tag)};
        e.rd = rd;
        e.chk_rd = chk_rd;
        e.err = err;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("Instruction_WB", instr_wb, e.instr);
            if (e.chk_rd) chk("Read_data_mem", rd_mem, e.rd);
            chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        reset = 0; stall = 0; instr_mem = 0; alu = 0; wdat = 0; dbg_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset Instruction_WB", instr_wb, 32'd0);
        chk("reset Read_data_mem", rd_mem, 32'd0);
        chk("reset mem_err", {31'd0, mem_err}, 32'd0);
        chk_dbg(3'd4, 32'd5);
        chk_dbg(3'd0, 32'd0);
        reset = 1;

        issue(SW,  1, 32'd392, 32'hDEADBEEF, 0, 0, 0);
        issue(LW,  2, 32'd392, 32'h0, 1, 32'hDEADBEEF, 0);
        issue(SB,  3, 32'd397, 32'hAAAAAA80, 0, 0, 0);
        issue(LB,  4, 32'd397, 32'h0, 1, 32'hFFFFFF80, 0);
        issue(LBU, 5, 32'd397, 32'h0, 1, 32'h00000080, 0);
        issue(LW,  6, 32'd396, 32'h0, 1, 32'h00008000, 0);
        issue(LW,  7, 32'd420, 32'h0, 1, 32'h0, 1);
        issue(SW,  8, 32'd390, 32'h12345678, 0, 0, 1);
        issue(LW,  9, 32'd384, 32'h0, 1, 32'h0, 1);
        issue(LW, 10, 32'd416, 32'h0, 1, 32'h0, 0);
        issue(LW, 11, 32'd404, 32'h0, 1, 32'h5, 0);
        issue(LB, 12, 32'd393, 32'h0, 1, 32'hFFFFFFBE, 0);
        issue(ADD, 13, 32'h1234, 32'h0, 1, 32'h1234, 0);
        @(negedge clk);
        chk_dbg(3'd0, 32'd0);
        chk_dbg(3'd1, 32'hDEADBEEF);
        chk_dbg(3'd2, 32'h00008000);

        stall = 1;
        instr_mem = {SW, 26'd14};
        alu = 32'd388;
        wdat = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall Instruction_WB", instr_wb, {ADD, 26'd13});
        chk("stall Read_data_mem", rd_mem, 32'h1234);
        chk("stall mem_err", {31'd0, mem_err}, 32'd0);
        chk_dbg(3'd0, 32'd0);
        stall = 0;

        issue(SW, 15, 32'd400, 32'hCAFEF00D, 0, 0, 0);
        @(negedge clk);
        chk_dbg(3'd3, 32'hCAFEF00D);
        reset = 0;
        stall = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        stall = 0;
        instr_mem = 0;
        chk("post-reset Instruction_WB", instr_wb, 32'd0);
        chk("post-reset Read_data_mem", rd_mem, 32'd0);
        chk("post-reset mem_err", {31'd0, mem_err}, 32'd0);
        chk_dbg(3'd3, 32'd0);
        chk_dbg(3'd1, 32'd0);
        chk_dbg(3'd4, 32'd5);

        repeat (2) @(negedge clk);
        chk("scoreboard drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
